// File: rtl/d_mem_pkg.sv
// Shared types and defaults for the MEM-stage data-memory controller.
// Optional feature macro: D_MEM_PARITY_EN (even-parity bit stored alongside each word).
package d_mem_pkg;

   localparam int DATA_W_DEF = 64;
   localparam int ADDR_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } state_t;

endpackage

// File: rtl/d_mem_ram.sv
// Single-port synchronous RAM with a registered read port (1-cycle latency).
// Contents are never cleared; only the read register returns to zero on reset.
module d_mem_ram #(
   parameter int W      = 64,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [W-1:0]      wdata,
   output logic [W-1:0]      rdata
);

   logic [W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (en && we) mem[addr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset)           rdata <= '0;
      else if (en && !we)  rdata <= mem[addr];
   end

endmodule

// File: rtl/d_mem_ctrl.sv
// MEM-stage data-memory controller: pipeline port, host port arbiter and starvation stall.
// Optional feature macro: D_MEM_PARITY_EN adds a stored parity bit and the parity_err pulse.
module d_mem_ctrl
   import d_mem_pkg::*;
#(
   parameter int DATA_W       = DATA_W_DEF,
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int STARVE_LIMIT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] D_addr,
   input  logic [DATA_W-1:0] WD_M,
   input  logic              MemWrite_M,
   input  logic              MemRead_M,
   output logic [DATA_W-1:0] RD_W,
   output logic              rd_valid_W,
   output logic              stall_req,
   input  logic              host_req,
   input  logic              host_we,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_ack,
   output logic [DATA_W-1:0] host_rdata,
   output logic              parity_err,
   output state_t            fsm_state,
   output logic [7:0]        wait_cnt
);

`ifdef D_MEM_PARITY_EN
   localparam int RAM_W = DATA_W + 1;
`else
   localparam int RAM_W = DATA_W;
`endif
   localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

   state_t            state;
   logic              pipe_busy, pipe_go, pipe_rd, host_go, host_rd_q;
   logic              ram_en, ram_we;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_wdata_raw, rd_hold, hrd_hold;
   logic [RAM_W-1:0]  ram_wdata, ram_q;

   assign fsm_state = state;
   assign pipe_busy = MemWrite_M | MemRead_M;
   assign stall_req = (state == WAIT) && (wait_cnt == LIMIT);
   // A stalled pipeline access is dropped; the host owns the port that cycle.
   assign pipe_go   = pipe_busy && !stall_req;
   assign pipe_rd   = pipe_go && MemRead_M && !MemWrite_M;
   assign host_go   = host_req && ((state == IDLE) || (state == WAIT)) && (!pipe_busy || stall_req);

   assign ram_en        = pipe_go | host_go;
   assign ram_we        = pipe_go ? MemWrite_M : host_we;
   assign ram_addr      = pipe_go ? D_addr : host_addr;
   assign ram_wdata_raw = pipe_go ? WD_M : host_wdata;

`ifdef D_MEM_PARITY_EN
   assign ram_wdata  = {^ram_wdata_raw, ram_wdata_raw};
   assign parity_err = (rd_valid_W | host_rd_q) & (^ram_q);
`else
   assign ram_wdata  = ram_wdata_raw;
   assign parity_err = 1'b0;
`endif

   // Outputs hold their last delivered word between valid pulses.
   assign RD_W       = rd_valid_W ? ram_q[DATA_W-1:0] : rd_hold;
   assign host_rdata = host_rd_q  ? ram_q[DATA_W-1:0] : hrd_hold;

   d_mem_ram #(.W(RAM_W), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .reset (reset),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_q)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         rd_valid_W <= 1'b0;
         host_ack   <= 1'b0;
         host_rd_q  <= 1'b0;
         rd_hold    <= '0;
         hrd_hold   <= '0;
      end else begin
         rd_valid_W <= pipe_rd;
         host_ack   <= host_go;
         host_rd_q  <= host_go && !host_we;
         rd_hold    <= RD_W;
         hrd_hold   <= host_rdata;
         case (state)
            IDLE: begin
               if (host_go) begin
                  state <= ACK;
               end else if (host_req) begin
                  state    <= WAIT;
                  wait_cnt <= 8'd1;
               end
            end
            WAIT: begin
               if (!host_req) begin
                  state    <= IDLE;
                  wait_cnt <= '0;
               end else if (host_go) begin
                  state <= ACK;
               end else if (wait_cnt < LIMIT) begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            ACK: begin
               state    <= IDLE;
               wait_cnt <= '0;
            end
            default: begin
               state    <= IDLE;
               wait_cnt <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_d_mem_ctrl.sv
// Directed bench for d_mem_ctrl: pipeline loads/stores, host port and starvation stall.
// Build with D_MEM_PARITY_EN defined to exercise the parity-error path.
module tb_d_mem_ctrl;
   import d_mem_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  D_addr;
   logic [63:0] WD_M;
   logic        MemWrite_M, MemRead_M;
   logic [63:0] RD_W;
   logic        rd_valid_W, stall_req;
   logic        host_req, host_we;
   logic [7:0]  host_addr;
   logic [63:0] host_wdata;
   logic        host_ack;
   logic [63:0] host_rdata;
   logic        parity_err;
   state_t      fsm_state;
   logic [7:0]  wait_cnt;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   d_mem_ctrl u_dut (
      .clk        (clk),
      .reset      (reset),
      .D_addr     (D_addr),
      .WD_M       (WD_M),
      .MemWrite_M (MemWrite_M),
      .MemRead_M  (MemRead_M),
      .RD_W       (RD_W),
      .rd_valid_W (rd_valid_W),
      .stall_req  (stall_req),
      .host_req   (host_req),
      .host_we    (host_we),
      .host_addr  (host_addr),
      .host_wdata (host_wdata),
      .host_ack   (host_ack),
      .host_rdata (host_rdata),
      .parity_err (parity_err),
      .fsm_state  (fsm_state),
      .wait_cnt   (wait_cnt)
   );

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pipe(input logic wr, input logic rd, input logic [7:0] a, input logic [63:0] d);
      MemWrite_M = wr;
      MemRead_M  = rd;
      D_addr     = a;
      WD_M       = d;
   endtask

   task automatic host(input logic req, input logic we, input logic [7:0] a, input logic [63:0] d);
      host_req   = req;
      host_we    = we;
      host_addr  = a;
      host_wdata = d;
   endtask

   initial begin
      reset = 1'b1;
      pipe(1'b0, 1'b0, 8'h00, 64'd0);
      host(1'b0, 1'b0, 8'h00, 64'd0);
      step();
      step();
      reset = 1'b0;
      check("rst_state", 64'(fsm_state), 64'(IDLE));
      check("rst_ack", 64'(host_ack), 64'd0);

      // Reset in the middle of a blocked host request drops it.
      pipe(1'b0, 1'b1, 8'h00, 64'd0);
      host(1'b1, 1'b0, 8'h04, 64'd0);
      step();
      check("pre_rst_wait", 64'(fsm_state), 64'(WAIT));
      step();
      reset = 1'b1;
      pipe(1'b0, 1'b0, 8'h00, 64'd0);
      host(1'b0, 1'b0, 8'h00, 64'd0);
      step();
      step();
      reset = 1'b0;
      check("rst2_rd", RD_W, 64'd0);
      check("rst2_rdv", 64'(rd_valid_W), 64'd0);
      check("rst2_stall", 64'(stall_req), 64'd0);
      check("rst2_ack", 64'(host_ack), 64'd0);
      check("rst2_hrd", host_rdata, 64'd0);
      check("rst2_perr", 64'(parity_err), 64'd0);
      check("rst2_state", 64'(fsm_state), 64'(IDLE));
      check("rst2_cnt", 64'(wait_cnt), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("rst2_no_ack", 64'(host_ack), 64'd0);
      end

      // Pipeline store then load, latency 1.
      pipe(1'b1, 1'b0, 8'h01, 64'd1);
      step();
      check("st_no_rdv", 64'(rd_valid_W), 64'd0);
      pipe(1'b0, 1'b1, 8'h01, 64'd0);
      step();
      check("ld1_data", RD_W, 64'd1);
      check("ld1_rdv", 64'(rd_valid_W), 64'd1);
      pipe(1'b0, 1'b0, 8'h00, 64'd0);
      step();
      check("ld1_rdv_pulse", 64'(rd_valid_W), 64'd0);

      // Back-to-back overwrite then read returns the new word.
      pipe(1'b1, 1'b0, 8'h01, 64'h55);
      step();
      pipe(1'b0, 1'b1, 8'h01, 64'd0);
      step();
      check("raw_data", RD_W, 64'h55);
      pipe(1'b0, 1'b0, 8'h00, 64'd0);

      // Host write then host read with the pipeline idle.
      host(1'b1, 1'b1, 8'h04, 64'd3);
      step();
      check("hw_ack", 64'(host_ack), 64'd1);
      check("hw_rdata_keep", host_rdata, 64'd0);
      host(1'b0, 1'b0, 8'h00, 64'd0);
      step();
      check("hw_ack_pulse", 64'(host_ack), 64'd0);
      host(1'b1, 1'b0, 8'h04, 64'd0);
      step();
      check("hr_ack", 64'(host_ack), 64'd1);
      check("hr_rdata", host_rdata, 64'd3);
      host(1'b0, 1'b0, 8'h00, 64'd0);
      step();
      check("hr_ack_pulse", 64'(host_ack), 64'd0);

      // Starvation: pipeline reads every cycle while the host waits.
      pipe(1'b0, 1'b1, 8'h01, 64'd0);
      host(1'b1, 1'b0, 8'h04, 64'd0);
      for (int n = 1; n <= 16; n++) begin
         check($sformatf("starve_stall_%0d", n), 64'(stall_req), 64'(n == 16));
         check($sformatf("starve_ack_%0d", n), 64'(host_ack), 64'd0);
         if (n == 16) check("starve_cnt", 64'(wait_cnt), 64'd15);
         step();
      end
      check("starve_ack", 64'(host_ack), 64'd1);
      check("starve_rdata", host_rdata, 64'd3);
      check("starve_pipe_dropped", 64'(rd_valid_W), 64'd0);
      check("starve_stall_off", 64'(stall_req), 64'd0);
      pipe(1'b0, 1'b0, 8'h00, 64'd0);
      host(1'b0, 1'b0, 8'h00, 64'd0);
      step();
      check("starve_cnt_clr", 64'(wait_cnt), 64'd0);
      check("starve_idle", 64'(fsm_state), 64'(IDLE));
      check("starve_ack_pulse", 64'(host_ack), 64'd0);

      // Simultaneous store and load strobes: store only.
      pipe(1'b1, 1'b1, 8'h02, 64'hFF);
      step();
      check("both_no_rdv", 64'(rd_valid_W), 64'd0);
      pipe(1'b0, 1'b1, 8'h02, 64'd0);
      step();
      check("both_mem2", RD_W, 64'hFF);
      pipe(1'b0, 1'b0, 8'h00, 64'd0);

      // Host read of a pipeline-written word.
      host(1'b1, 1'b0, 8'h02, 64'd0);
      step();
      check("cross_rdata", host_rdata, 64'hFF);
      host(1'b0, 1'b0, 8'h00, 64'd0);
      step();

      // Parity path at address 5.
      pipe(1'b1, 1'b0, 8'h05, 64'h5);
      step();
`ifdef D_MEM_PARITY_EN
      pipe(1'b0, 1'b1, 8'h05, 64'd0);
      step();
      check("par_clean", 64'(parity_err), 64'd0);
      u_dut.u_ram.mem[5][0] = ~u_dut.u_ram.mem[5][0];
      step();
      check("par_err", 64'(parity_err), 64'd1);
      check("par_rdv", 64'(rd_valid_W), 64'd1);
      pipe(1'b0, 1'b0, 8'h00, 64'd0);
      step();
      check("par_pulse", 64'(parity_err), 64'd0);
`else
      pipe(1'b0, 1'b1, 8'h05, 64'd0);
      step();
      check("nopar_data", RD_W, 64'h5);
      check("nopar_err", 64'(parity_err), 64'd0);
      pipe(1'b0, 1'b0, 8'h00, 64'd0);
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
